// File: rtl/io_bridge.sv
// io_bridge: data-bus responder for the core's MEM stage. Low address space
// goes to DRAM; the 0xFFFFF000 page holds the display, timer, LED, switch
// and button registers. Reads are combinational, writes commit on the edge.
module io_bridge #(
    parameter int DRAM_AW  = 14,
    parameter int SCAN_DIV = 2000
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [31:0]        Bus_addr,
    input  logic               Bus_wen,
    input  logic [31:0]        Bus_wdata,
    output logic [31:0]        Bus_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_wen,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         button,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         dig_seg
);
    localparam int SCNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [11:0] OFF_DIG   = 12'h000;
    localparam logic [11:0] OFF_TIMER = 12'h020;
    localparam logic [11:0] OFF_TDIV  = 12'h024;
    localparam logic [11:0] OFF_LED   = 12'h060;
    localparam logic [11:0] OFF_SW    = 12'h070;
    localparam logic [11:0] OFF_BTN   = 12'h078;

    logic              periph;
    logic [11:0]       off;
    logic              pwr;
    logic [31:0]       dig_r, timer_r, tdiv_r, pcnt;
    logic [23:0]       led_r, sw_meta, sw_sync;
    logic [4:0]        btn_meta, btn_sync;
    logic [SCNT_W-1:0] scnt;
    logic [2:0]        idx;
    logic              tick;

    assign periph     = (Bus_addr[31:12] == 20'hFFFFF);
    assign off        = Bus_addr[11:0];
    assign pwr        = Bus_wen & periph;
    assign dram_wen   = Bus_wen & ~periph;
    assign dram_addr  = Bus_addr[DRAM_AW+1:2];
    assign dram_wdata = Bus_wdata;
    assign led        = led_r;
    assign tick       = (pcnt == tdiv_r);

    // active-low seven-segment pattern, dp held off
    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 8'hC0;  4'h1: hex_seg = 8'hF9;
            4'h2: hex_seg = 8'hA4;  4'h3: hex_seg = 8'hB0;
            4'h4: hex_seg = 8'h99;  4'h5: hex_seg = 8'h92;
            4'h6: hex_seg = 8'h82;  4'h7: hex_seg = 8'hF8;
            4'h8: hex_seg = 8'h80;  4'h9: hex_seg = 8'h90;
            4'hA: hex_seg = 8'h88;  4'hB: hex_seg = 8'h83;
            4'hC: hex_seg = 8'hC6;  4'hD: hex_seg = 8'hA1;
            4'hE: hex_seg = 8'h86;  default: hex_seg = 8'h8E;
        endcase
    endfunction

    // load data: DRAM passthrough or peripheral register select
    always_comb begin
        Bus_rdata = 32'h0;
        if (!periph) begin
            Bus_rdata = dram_rdata;
        end else begin
            case (off)
                OFF_DIG:   Bus_rdata = dig_r;
                OFF_TIMER: Bus_rdata = timer_r;
                OFF_TDIV:  Bus_rdata = tdiv_r;
                OFF_LED:   Bus_rdata = {8'h0, led_r};
                OFF_SW:    Bus_rdata = {8'h0, sw_sync};
                OFF_BTN:   Bus_rdata = {27'h0, btn_sync};
                default:   Bus_rdata = 32'h0;
            endcase
        end
    end

    // display drive comes only from registered idx and DIG
    always_comb begin
        dig_en  = ~(8'b1 << idx);
        dig_seg = hex_seg(dig_r[{idx, 2'b00} +: 4]);
    end

    // writable registers; a TIMER store beats the same-cycle increment,
    // a TDIV store restarts the prescaler
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            dig_r   <= 32'h0;
            timer_r <= 32'h0;
            tdiv_r  <= 32'h0;
            pcnt    <= 32'h0;
            led_r   <= 24'h0;
        end else begin
            if (pwr && off == OFF_DIG) dig_r <= Bus_wdata;
            if (pwr && off == OFF_LED) led_r <= Bus_wdata[23:0];

            if (pwr && off == OFF_TDIV) begin
                tdiv_r <= Bus_wdata;
                pcnt   <= 32'h0;
            end else if (tick) begin
                pcnt <= 32'h0;
            end else begin
                pcnt <= pcnt + 32'd1;
            end

            if (pwr && off == OFF_TIMER) timer_r <= Bus_wdata;
            else if (tick)               timer_r <= timer_r + 32'd1;
        end
    end

    // two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            sw_meta  <= 24'h0;
            sw_sync  <= 24'h0;
            btn_meta <= 5'h0;
            btn_sync <= 5'h0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= button;
            btn_sync <= btn_meta;
        end
    end

    // digit scanner: hold each digit SCAN_DIV cycles, then step idx
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            scnt <= '0;
            idx  <= 3'd0;
        end else if (scnt == SCNT_W'(SCAN_DIV - 1)) begin
            scnt <= '0;
            idx  <= idx + 3'd1;
        end else begin
            scnt <= scnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge: display scan, LED/switch/button registers,
// timer prescale and wrap, DRAM routing and reset behaviour.
module tb_io_bridge;
    localparam int DRAM_AW  = 14;
    localparam int SCAN_DIV = 4;

    logic               cpu_clk = 1'b0;
    logic               cpu_rst;
    logic [31:0]        Bus_addr;
    logic               Bus_wen;
    logic [31:0]        Bus_wdata;
    logic [31:0]        Bus_rdata;
    logic [DRAM_AW-1:0] dram_addr;
    logic               dram_wen;
    logic [31:0]        dram_wdata;
    logic [31:0]        dram_rdata;
    logic [23:0]        sw;
    logic [4:0]         button;
    logic [23:0]        led;
    logic [7:0]         dig_en;
    logic [7:0]         dig_seg;

    int tests = 0;
    int fails = 0;

    io_bridge #(.DRAM_AW(DRAM_AW), .SCAN_DIV(SCAN_DIV)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_wdata(Bus_wdata),
        .Bus_rdata(Bus_rdata),
        .dram_addr(dram_addr), .dram_wen(dram_wen), .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata),
        .sw(sw), .button(button), .led(led),
        .dig_en(dig_en), .dig_seg(dig_seg)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge cpu_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_v);
        Bus_addr = addr;
        #1;
        check(tag, Bus_rdata, exp_v);
    endtask

    initial begin
        cpu_rst    = 1'b0;
        Bus_addr   = 32'h0;
        Bus_wen    = 1'b0;
        Bus_wdata  = 32'h0;
        dram_rdata = 32'h13579BDF;
        sw         = 24'h0;
        button     = 5'h0;
        step(3);

        // reset state
        check("rst_led", {8'h0, led}, 32'h0);
        check("rst_dig_en", {24'h0, dig_en}, 32'hFE);
        check("rst_dig_seg", {24'h0, dig_seg}, 32'hC0);
        rd("rst_timer", 32'hFFFFF020, 32'h0);
        rd("rst_dig", 32'hFFFFF000, 32'h0);

        // release reset with a DIG store on the first edge
        cpu_rst   = 1'b1;
        Bus_addr  = 32'hFFFFF000;
        Bus_wen   = 1'b1;
        Bus_wdata = 32'h12345678;
        step(1);
        Bus_wen = 1'b0;
        rd("dig_read", 32'hFFFFF000, 32'h12345678);
        check("dig_seg_d0", {24'h0, dig_seg}, 32'h80);
        check("dig_en_d0", {24'h0, dig_en}, 32'hFE);
        step(2);
        check("dig_en_hold", {24'h0, dig_en}, 32'hFE);
        step(1);
        check("dig_en_d1", {24'h0, dig_en}, 32'hFD);
        check("dig_seg_d1", {24'h0, dig_seg}, 32'hF8);

        // LED store, dram_wen suppressed on the peripheral page
        Bus_addr  = 32'hFFFFF060;
        Bus_wdata = 32'hFFABCDEF;
        Bus_wen   = 1'b1;
        #1;
        check("periph_dram_wen", {31'h0, dram_wen}, 32'h0);
        step(1);
        Bus_wen = 1'b0;
        check("led_out", {8'h0, led}, 32'h00ABCDEF);
        rd("led_read", 32'hFFFFF060, 32'h00ABCDEF);

        // store to read-only SW offset is ignored
        Bus_addr  = 32'hFFFFF070;
        Bus_wdata = 32'h00FFFFFF;
        Bus_wen   = 1'b1;
        step(1);
        Bus_wen = 1'b0;
        rd("sw_ro", 32'hFFFFF070, 32'h0);
        check("led_kept", {8'h0, led}, 32'h00ABCDEF);

        // switch and button synchronizers: two edges
        sw     = 24'h5A5A5A;
        button = 5'h15;
        step(1);
        rd("sw_1edge", 32'hFFFFF070, 32'h0);
        step(1);
        rd("sw_2edge", 32'hFFFFF070, 32'h005A5A5A);
        rd("btn_2edge", 32'hFFFFF078, 32'h00000015);

        // timer: TDIV=3 then TIMER=FFFFFFFE; pcnt is 1 after the TIMER store
        Bus_addr  = 32'hFFFFF024;
        Bus_wdata = 32'd3;
        Bus_wen   = 1'b1;
        step(1);
        Bus_addr  = 32'hFFFFF020;
        Bus_wdata = 32'hFFFFFFFE;
        step(1);
        Bus_wen = 1'b0;
        rd("tdiv_read", 32'hFFFFF024, 32'd3);
        rd("timer_load", 32'hFFFFF020, 32'hFFFFFFFE);
        step(2);
        rd("timer_pre", 32'hFFFFF020, 32'hFFFFFFFE);
        step(1);
        rd("timer_inc", 32'hFFFFF020, 32'hFFFFFFFF);
        step(3);
        rd("timer_hold", 32'hFFFFF020, 32'hFFFFFFFF);
        step(1);
        rd("timer_wrap", 32'hFFFFF020, 32'h0);

        // TIMER store on the same edge as a tick: written value wins
        step(3);
        Bus_wdata = 32'hCAFE0000;
        Bus_wen   = 1'b1;
        step(1);
        Bus_wen = 1'b0;
        rd("timer_collide", 32'hFFFFF020, 32'hCAFE0000);
        step(3);
        rd("timer_post_hold", 32'hFFFFF020, 32'hCAFE0000);
        step(1);
        rd("timer_post_inc", 32'hFFFFF020, 32'hCAFE0001);

        // DRAM routing
        Bus_addr  = 32'h00000100;
        Bus_wdata = 32'h0000DEAD;
        Bus_wen   = 1'b1;
        #1;
        check("dram_wen", {31'h0, dram_wen}, 32'h1);
        check("dram_addr", {18'h0, dram_addr}, 32'h40);
        check("dram_wdata", dram_wdata, 32'h0000DEAD);
        step(1);
        Bus_wen = 1'b0;
        rd("dram_read", 32'h00000100, 32'h13579BDF);
        rd("unmapped", 32'hFFFFF100, 32'h0);

        // reset mid-scan with a concurrent DIG store
        step(2);
        cpu_rst   = 1'b0;
        Bus_addr  = 32'hFFFFF000;
        Bus_wdata = 32'hFFFFFFFF;
        Bus_wen   = 1'b1;
        step(1);
        cpu_rst = 1'b1;
        Bus_wen = 1'b0;
        rd("rst2_dig", 32'hFFFFF000, 32'h0);
        rd("rst2_timer", 32'hFFFFF020, 32'h0);
        rd("rst2_tdiv", 32'hFFFFF024, 32'h0);
        rd("rst2_led_rd", 32'hFFFFF060, 32'h0);
        rd("rst2_sw", 32'hFFFFF070, 32'h0);
        check("rst2_dig_en", {24'h0, dig_en}, 32'hFE);
        check("rst2_dig_seg", {24'h0, dig_seg}, 32'hC0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
